data_memory_responder: RTL

- Responder end of the CPU data-memory interface.
- Accepts the MEM-stage load/store request (DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA).
- Models a multi-cycle byte-addressable RAM and holds DATA_MEM_BUSYWAIT high until the access completes.
- Returns load data sign- or zero-extended, ready for the MEM/WB pipeline register.

---
 rtl/data_memory_responder_pkg.sv | 52 +++++
 rtl/data_memory_responder_if.sv | 21 ++
 rtl/data_memory_responder_lsu_lane_align.sv | 56 +++++
 rtl/data_memory_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared codes for the data-memory responder: request field encodings,
// access sizes and FSM states.
package data_memory_responder_pkg;

   localparam int READ_EN_BIT  = 3;
   localparam int WRITE_EN_BIT = 2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] ST_SIZE_SB = 2'b00;
   localparam logic [1:0] ST_SIZE_SH = 2'b01;
   localparam logic [1:0] ST_SIZE_SW = 2'b10;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_ACK    = 2'b10
   } state_e;

   // Unlisted funct3 codes fall back to a full-word load.
   function automatic size_e load_size(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: load_size = SIZE_BYTE;
         F3_LH, F3_LHU: load_size = SIZE_HALF;
         default:       load_size = SIZE_WORD;
      endcase
   endfunction

   function automatic logic load_unsigned(input logic [2:0] f3);
      load_unsigned = (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Size code 11 behaves as a word store.
   function automatic size_e store_size(input logic [1:0] sz);
      case (sz)
         ST_SIZE_SB: store_size = SIZE_BYTE;
         ST_SIZE_SH: store_size = SIZE_HALF;
         default:    store_size = SIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// CPU data-memory bus: the CPU (master) issues load/store requests and the
// responder (slave) returns busywait, load data and the misaligned flag.
interface data_memory_responder_if;
   logic [3:0]  READ;
   logic [2:0]  WRITE;
   logic [31:0] ADDR;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        MISALIGNED;

   modport master (
      output READ, WRITE, ADDR, WRITE_DATA,
      input  READ_DATA, BUSYWAIT, MISALIGNED
   );

   modport slave (
      input  READ, WRITE, ADDR, WRITE_DATA,
      output READ_DATA, BUSYWAIT, MISALIGNED
   );
endinterface

// File: rtl/data_memory_responder_lsu_lane_align.sv
// Byte-lane steering for one access: lane mask and replicated store data,
// extraction plus extension of a load from the raw word, alignment check.
module lsu_lane_align
   import data_memory_responder_pkg::*;
(
   input  logic        i_is_store,
   input  logic [1:0]  i_store_size,
   input  logic [2:0]  i_load_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_write_data,
   input  logic [31:0] i_raw_word,
   output logic [3:0]  o_byte_en,
   output logic [31:0] o_write_word,
   output logic [31:0] o_read_ext,
   output logic        o_misaligned
);

   size_e       w_size;
   logic        w_unsigned;
   logic [1:0]  w_offset;
   logic [31:0] w_shifted;

   assign w_size     = i_is_store ? store_size(i_store_size) : load_size(i_load_funct3);
   assign w_unsigned = load_unsigned(i_load_funct3);
   assign w_shifted  = i_raw_word >> {w_offset, 3'b000};

   always_comb begin
      w_offset     = 2'b00;
      o_byte_en    = 4'b1111;
      o_write_word = i_write_data;
      o_read_ext   = w_shifted;
      o_misaligned = 1'b0;
      case (w_size)
         SIZE_BYTE: begin
            w_offset     = i_addr_lo;
            o_byte_en    = 4'b0001 << i_addr_lo;
            o_write_word = {4{i_write_data[7:0]}};
            o_read_ext   = w_unsigned ? {24'h000000, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
         end
         SIZE_HALF: begin
            // Halfwords always land on an even address; bit 0 is dropped.
            w_offset     = {i_addr_lo[1], 1'b0};
            o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_write_word = {2{i_write_data[15:0]}};
            o_read_ext   = w_unsigned ? {16'h0000, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
            o_misaligned = i_addr_lo[0];
         end
         default: begin
            o_misaligned = |i_addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle byte-addressable data RAM answering the CPU MEM stage; stalls
// the CPU with BUSYWAIT for LATENCY+1 cycles per request.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   data_memory_responder_if.slave mem
);

   localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e                  r_state;
   state_e                  w_state_next;
   logic [3:0]              r_count;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [31:0]             r_wdata;
   logic [3:0]              r_read;
   logic [2:0]              r_write;
   logic [31:0]             r_read_data;

   logic                    w_request;
   logic                    w_is_store;
   logic                    w_is_load;
   logic                    w_done;
   logic                    w_accept;
   logic                    w_busywait;
   logic                    w_mem_we;
   logic                    w_load_commit;
   logic                    w_mis_out;
   logic [3:0]              w_byte_en;
   logic [31:0]             w_write_word;
   logic [31:0]             w_read_ext;
   logic                    w_misaligned;
   logic [31:0]             w_raw_word;
   logic                    w_unused_addr_hi;

   assign w_request        = mem.READ[READ_EN_BIT] | mem.WRITE[WRITE_EN_BIT];
   assign w_is_store       = r_write[WRITE_EN_BIT];
   assign w_is_load        = r_read[READ_EN_BIT] & ~w_is_store;
   assign w_done           = (r_state == ST_ACCESS) && (r_count == 4'd0);
   assign w_unused_addr_hi = ^mem.ADDR[31:ADDR_WIDTH];

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_request) w_state_next = ST_ACCESS;
         ST_ACCESS: if (r_count == 4'd0) w_state_next = ST_ACK;
         ST_ACK:    w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Output / control decode.
   always_comb begin
      w_busywait    = 1'b0;
      w_accept      = 1'b0;
      w_mem_we      = 1'b0;
      w_load_commit = 1'b0;
      w_mis_out     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busywait = w_request;
            w_accept   = w_request;
         end
         ST_ACCESS: begin
            w_busywait    = 1'b1;
            w_mem_we      = w_done & w_is_store & ~RESET;
            w_load_commit = w_done & w_is_load;
         end
         ST_ACK: begin
            w_mis_out = w_misaligned;
         end
         default: ;
      endcase
   end

   // Request latches, latency counter and load result register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_count     <= 4'd0;
         r_read_data <= 32'h0;
      end else begin
         if (w_accept) begin
            r_count <= CNT_LOAD;
            r_addr  <= mem.ADDR[ADDR_WIDTH-1:0];
            r_wdata <= mem.WRITE_DATA;
            r_read  <= mem.READ;
            r_write <= mem.WRITE;
         end else if (r_state == ST_ACCESS && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
         end
         if (w_load_commit) r_read_data <= w_read_ext;
      end
   end

   lsu_lane_align u_lane_align (
      .i_is_store    (w_is_store),
      .i_store_size  (r_write[1:0]),
      .i_load_funct3 (r_read[2:0]),
      .i_addr_lo     (r_addr[1:0]),
      .i_write_data  (r_wdata),
      .i_raw_word    (w_raw_word),
      .o_byte_en     (w_byte_en),
      .o_write_word  (w_write_word),
      .o_read_ext    (w_read_ext),
      .o_misaligned  (w_misaligned)
   );

   // One RAM per byte lane. The word is read on the accept edge; nothing can
   // write it before the access completes, so it is still current at the end.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_lane_mem [0:WORDS-1];
         logic [7:0] r_raw_byte;

         always_ff @(posedge CLK) begin
            if (w_mem_we && w_byte_en[gi])
               r_lane_mem[r_addr[ADDR_WIDTH-1:2]] <= w_write_word[8*gi +: 8];
            if (w_accept)
               r_raw_byte <= r_lane_mem[mem.ADDR[ADDR_WIDTH-1:2]];
         end

         assign w_raw_word[8*gi +: 8] = r_raw_byte;
      end
   endgenerate

   assign mem.BUSYWAIT   = w_busywait;
   assign mem.READ_DATA  = r_read_data;
   assign mem.MISALIGNED = w_mis_out;

endmodule
